polygon_vertex_loader: RTL and testbench
========================================

# polygon_vertex_loader

Collects a polygon's vertices serially over a valid/ready stream and assembles them in a shadow buffer. On a frame boundary it commits the complete polygon to a stable active set. The active set drives the per-pixel in-polygon winding test directly, so the vertex arrays that test sees never change mid-frame. Unused vertex slots are filled with copies of the last real vertex. A repeated vertex gives a zero-angle edge, so padding does not disturb the winding sum.

## Interface
- MAX_NUM_VERTICES, default 4: vertex slots per polygon; must be ≥ 3.
- COORD_WIDTH, default 32: signed coordinate width; matches the in-polygon test inputs.
- clk_in  input  1  pixel clock.
- rst_n_in  input  1  reset; one clock; reset is asynchronous and active-low.
- vertex_valid_in  input  1  vertex beat present.
- vertex_x_in  input  COORD_WIDTH signed  vertex x, in pixels.
- vertex_y_in  input  COORD_WIDTH signed  vertex y, in pixels.
- vertex_last_in  input  1  final vertex of this polygon.
- vertex_ready_out  output  1  loader can accept a beat.
- frame_start_in  input  1  single-cycle pulse at the start of vertical blanking.
- xs_out  output  COORD_WIDTH signed × MAX_NUM_VERTICES  active x array.
- ys_out  output  COORD_WIDTH signed × MAX_NUM_VERTICES  active y array.
- num_vertices_out  output  $clog2(MAX_NUM_VERTICES+1)  real vertex count in the active set.
- polygon_valid_out  output  1  active set holds a committed polygon.
- error_out  output  1  one-cycle pulse when a polygon is rejected or truncated.

## Operation
- A beat is accepted on a clock edge where vertex_valid_in and vertex_ready_out are both high.
- vertex_ready_out is driven combinationally from state: high in IDLE and COLLECT, low in PENDING.
- States:
  - IDLE: shadow empty, count 0. An accepted beat writes slot 0 and moves to COLLECT, or to PENDING if vertex_last_in is set.
  - COLLECT: each accepted beat writes slot count and increments count. A beat with vertex_last_in moves to PENDING.
  - PENDING: the shadow polygon is complete; no beats are accepted. frame_start_in commits and returns to IDLE.
- Commit:
  - active[i] = shadow[i] for i < count; active[i] = shadow[count-1] for i ≥ count.
  - num_vertices_out = count; polygon_valid_out = 1.
- frame_start_in in IDLE or COLLECT has no effect. The active set is held, and a partial polygon keeps collecting across the frame boundary.
- Overflow: beats arriving after MAX_NUM_VERTICES are accepted, so the stream never stalls, but their data is dropped. When the last beat arrives, error_out pulses and the polygon enters PENDING truncated to MAX_NUM_VERTICES.
- Underflow: if the last beat arrives with a total count < 3, the polygon is discarded. error_out pulses, the state returns to IDLE, and the active set is untouched.
- A last beat and frame_start_in in the same cycle: the state is still COLLECT, so there is no commit that cycle. The polygon commits at the next frame_start_in.
- Reset, asserted at any time including mid-polygon, forces the reset values below and the IDLE state. The partial shadow is discarded.

## Timing
- Reset values:
  - xs_out, ys_out, num_vertices_out, polygon_valid_out, error_out all 0.
  - State IDLE, so vertex_ready_out = 1 once reset is released.
- Commit latency: the active outputs update on the edge that samples frame_start_in and are visible the following cycle.
- xs_out, ys_out and num_vertices_out are registered and change only at a commit.
- error_out is registered; it pulses the cycle after the offending last beat.
- Throughput: one vertex per cycle in IDLE and COLLECT. A new polygon can begin the cycle after a commit.

## Configuration
- POLY_LOADER_STATS_EN defined:
  - Adds outputs commit_count_out[15:0] and drop_count_out[15:0].
  - Both are saturating counters, reset to 0.
  - commit_count_out increments at every commit.
  - drop_count_out increments at every error_out pulse, whether the polygon was discarded or truncated.
- POLY_LOADER_STATS_EN undefined: these ports and counters do not exist; all other behaviour is identical.

## Structure
- Shared package poly_pkg holds:
  - The loader state enum (IDLE, COLLECT, PENDING).
  - localparam MIN_POLY_VERTICES = 3.
  - The coordinate type, shared with the in-polygon test.
- No sub-module. The block is one FSM, a shadow array with a count register, and an active array written only at commit.

## Test plan
- Reset, then stream the square (100,100) (200,100) (200,200) (100,200) with last on the 4th beat, then pulse frame_start -> next cycle xs = {100,200,200,100}, num = 4, valid = 1, ready = 1.
- Stream the triangle (10,10) (50,10) (30,40) with MAX = 4, then frame_start -> slot 3 = (30,40), num = 3.
- Stream 6 beats with last on the 6th, MAX = 4 -> ready never drops, error pulses once, the committed polygon holds only beats 1–4.
- Stream 2 beats with last on the 2nd -> error pulse, state IDLE, a following frame_start leaves the active set unchanged.
- Issue frame_start in the same cycle as the last beat -> no commit; commit at the next frame_start. Also: assert reset mid-stream -> all outputs 0 and ready = 1 after release.

Source files
------------

// File: rtl/poly_pkg.sv
// Shared types for the polygon loader and the in-polygon winding test.
package poly_pkg;

    // Fewest vertices that still enclose an area.
    localparam int unsigned MIN_POLY_VERTICES = 3;

    // Default coordinate width, common to the loader and the winding test.
    localparam int unsigned COORD_WIDTH_DEF = 32;

    // Signed pixel coordinate.
    typedef logic signed [COORD_WIDTH_DEF-1:0] coord_t;

    // Loader FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PENDING = 2'd2
    } loader_state_e;

endpackage

// File: rtl/polygon_vertex_loader.sv
// Polygon vertex loader: collects vertices into a shadow buffer and commits
// them to a stable active set on frame_start_in. Unused active slots repeat
// the last real vertex, so they add zero-angle edges to the winding sum.
// Optional build macro: POLY_LOADER_STATS_EN adds commit and drop counters.
module polygon_vertex_loader
    import poly_pkg::*;
#(
    parameter int unsigned MAX_NUM_VERTICES = 4,
    parameter int unsigned COORD_WIDTH      = COORD_WIDTH_DEF
) (
    input  logic                                        clk_in,
    input  logic                                        rst_n_in,
    input  logic                                        vertex_valid_in,
    input  logic signed [COORD_WIDTH-1:0]               vertex_x_in,
    input  logic signed [COORD_WIDTH-1:0]               vertex_y_in,
    input  logic                                        vertex_last_in,
    output logic                                        vertex_ready_out,
    input  logic                                        frame_start_in,
    output logic [MAX_NUM_VERTICES*COORD_WIDTH-1:0]     xs_out,
    output logic [MAX_NUM_VERTICES*COORD_WIDTH-1:0]     ys_out,
    output logic [$clog2(MAX_NUM_VERTICES+1)-1:0]       num_vertices_out,
    output logic                                        polygon_valid_out,
    output logic                                        error_out
`ifdef POLY_LOADER_STATS_EN
    ,
    output logic [15:0]                                 commit_count_out,
    output logic [15:0]                                 drop_count_out
`endif
);

    localparam int unsigned CNT_W = $clog2(MAX_NUM_VERTICES + 1);
    localparam int unsigned ARR_W = MAX_NUM_VERTICES * COORD_WIDTH;

    loader_state_e state_q, state_d;

    logic [CNT_W-1:0]             count_q, count_d;
    logic                         ovf_q, ovf_d;
    logic signed [COORD_WIDTH-1:0] shx_q [MAX_NUM_VERTICES];
    logic signed [COORD_WIDTH-1:0] shy_q [MAX_NUM_VERTICES];
    logic signed [COORD_WIDTH-1:0] shx_d [MAX_NUM_VERTICES];
    logic signed [COORD_WIDTH-1:0] shy_d [MAX_NUM_VERTICES];

    logic [ARR_W-1:0] xs_q, xs_d;
    logic [ARR_W-1:0] ys_q, ys_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic             valid_q, valid_d;
    logic             error_q, error_d;
    logic             commit_c;

    logic             accept_c;
    logic             full_c;
    logic signed [COORD_WIDTH-1:0] last_x_c, last_y_c;

    // Beats are taken whenever the shadow is not holding a finished polygon.
    assign vertex_ready_out = (state_q != PENDING);
    assign accept_c         = vertex_valid_in && vertex_ready_out;
    assign full_c           = (count_q == CNT_W'(MAX_NUM_VERTICES));

    // Last real vertex in the shadow, used to pad unused active slots.
    always_comb begin
        last_x_c = shx_q[0];
        last_y_c = shy_q[0];
        for (int i = 0; i < MAX_NUM_VERTICES; i++) begin
            if (CNT_W'(i + 1) == count_q) begin
                last_x_c = shx_q[i];
                last_y_c = shy_q[i];
            end
        end
    end

    // Next-state, shadow write, commit and error logic.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        shx_d    = shx_q;
        shy_d    = shy_q;
        xs_d     = xs_q;
        ys_d     = ys_q;
        num_d    = num_q;
        valid_d  = valid_q;
        error_d  = 1'b0;
        commit_c = 1'b0;

        case (state_q)
            IDLE, COLLECT: begin
                if (accept_c) begin
                    if (!full_c) begin
                        for (int i = 0; i < MAX_NUM_VERTICES; i++) begin
                            if (CNT_W'(i) == count_q) begin
                                shx_d[i] = vertex_x_in;
                                shy_d[i] = vertex_y_in;
                            end
                        end
                        count_d = count_q + CNT_W'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end

                    if (vertex_last_in) begin
                        if (count_q < CNT_W'(MIN_POLY_VERTICES - 1)) begin
                            // Too few vertices: discard, active set untouched.
                            error_d = 1'b1;
                            state_d = IDLE;
                            count_d = '0;
                            ovf_d   = 1'b0;
                        end else begin
                            // Truncated if any beat (including this one) was dropped.
                            error_d = ovf_q || full_c;
                            state_d = PENDING;
                        end
                    end else begin
                        state_d = COLLECT;
                    end
                end
            end

            PENDING: begin
                if (frame_start_in) begin
                    commit_c = 1'b1;
                    for (int i = 0; i < MAX_NUM_VERTICES; i++) begin
                        if (CNT_W'(i) < count_q) begin
                            xs_d[i*COORD_WIDTH +: COORD_WIDTH] = shx_q[i];
                            ys_d[i*COORD_WIDTH +: COORD_WIDTH] = shy_q[i];
                        end else begin
                            xs_d[i*COORD_WIDTH +: COORD_WIDTH] = last_x_c;
                            ys_d[i*COORD_WIDTH +: COORD_WIDTH] = last_y_c;
                        end
                    end
                    num_d   = count_q;
                    valid_d = 1'b1;
                    state_d = IDLE;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
                count_d = '0;
                ovf_d   = 1'b0;
            end
        endcase
    end

    // State, shadow and active-set registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            count_q <= '0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < MAX_NUM_VERTICES; i++) begin
                shx_q[i] <= '0;
                shy_q[i] <= '0;
            end
            xs_q    <= '0;
            ys_q    <= '0;
            num_q   <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            shx_q   <= shx_d;
            shy_q   <= shy_d;
            xs_q    <= xs_d;
            ys_q    <= ys_d;
            num_q   <= num_d;
            valid_q <= valid_d;
            error_q <= error_d;
        end
    end

    assign xs_out            = xs_q;
    assign ys_out            = ys_q;
    assign num_vertices_out  = num_q;
    assign polygon_valid_out = valid_q;
    assign error_out         = error_q;

`ifdef POLY_LOADER_STATS_EN
    logic [15:0] commit_cnt_q, commit_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Saturating commit and drop counters.
    always_comb begin
        commit_cnt_d = commit_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        if (commit_c && (commit_cnt_q != 16'hFFFF)) begin
            commit_cnt_d = commit_cnt_q + 16'd1;
        end
        if (error_d && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            commit_cnt_q <= '0;
            drop_cnt_q   <= '0;
        end else begin
            commit_cnt_q <= commit_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign commit_count_out = commit_cnt_q;
    assign drop_count_out   = drop_cnt_q;
`endif

endmodule

// File: tb/tb_polygon_vertex_loader.sv
// Directed self-checking bench for polygon_vertex_loader (MAX = 4, 32-bit coords).
module tb_polygon_vertex_loader;

    logic         clk;
    logic         rst_n;
    logic         vvalid;
    logic [31:0]  vx;
    logic [31:0]  vy;
    logic         vlast;
    logic         vready;
    logic         fstart;
    logic [127:0] xs;
    logic [127:0] ys;
    logic [2:0]   num;
    logic         pvalid;
    logic         err;
`ifdef POLY_LOADER_STATS_EN
    logic [15:0]  commit_cnt;
    logic [15:0]  drop_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    polygon_vertex_loader #(
        .MAX_NUM_VERTICES(4),
        .COORD_WIDTH(32)
    ) dut (
        .clk_in           (clk),
        .rst_n_in         (rst_n),
        .vertex_valid_in  (vvalid),
        .vertex_x_in      (vx),
        .vertex_y_in      (vy),
        .vertex_last_in   (vlast),
        .vertex_ready_out (vready),
        .frame_start_in   (fstart),
        .xs_out           (xs),
        .ys_out           (ys),
        .num_vertices_out (num),
        .polygon_valid_out(pvalid),
        .error_out        (err)
`ifdef POLY_LOADER_STATS_EN
        ,
        .commit_count_out (commit_cnt),
        .drop_count_out   (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [127:0] pack4(input int a, input int b, input int c, input int d);
        return {32'(d), 32'(c), 32'(b), 32'(a)};
    endfunction

    // Present one beat (optionally with frame_start) for exactly one clock edge.
    task automatic send_beat(input int x, input int y, input logic last, input logic fs);
        vvalid = 1'b1;
        vx     = 32'(x);
        vy     = 32'(y);
        vlast  = last;
        fstart = fs;
        @(posedge clk);
        #1;
        vvalid = 1'b0;
        vlast  = 1'b0;
        fstart = 1'b0;
    endtask

    task automatic pulse_frame();
        fstart = 1'b1;
        @(posedge clk);
        #1;
        fstart = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; vvalid = 1'b0; vx = '0; vy = '0; vlast = 1'b0; fstart = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (xs !== 128'd0) begin n_bad++; $display("FAIL reset_xs got %h want 0", xs); end
        n_cmp++; if ({num, pvalid, err} !== 5'd0) begin n_bad++; $display("FAIL reset_ctl got %b want 00000", {num, pvalid, err}); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (vready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", vready); end
    endtask

    task automatic test_square();
        send_beat(100, 100, 1'b0, 1'b0);
        send_beat(200, 100, 1'b0, 1'b0);
        send_beat(200, 200, 1'b0, 1'b0);
        send_beat(100, 200, 1'b1, 1'b0);
        n_cmp++; if (vready !== 1'b0) begin n_bad++; $display("FAIL square_pending_ready got %b want 0", vready); end
        n_cmp++; if (pvalid !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL square_precommit got valid=%b err=%b want 0 0", pvalid, err); end
        pulse_frame();
        n_cmp++; if (xs !== pack4(100, 200, 200, 100)) begin n_bad++; $display("FAIL square_xs got %h want %h", xs, pack4(100, 200, 200, 100)); end
        n_cmp++; if (ys !== pack4(100, 100, 200, 200)) begin n_bad++; $display("FAIL square_ys got %h want %h", ys, pack4(100, 100, 200, 200)); end
        n_cmp++; if (num !== 3'd4 || pvalid !== 1'b1 || vready !== 1'b1) begin n_bad++; $display("FAIL square_ctl got num=%0d valid=%b ready=%b want 4 1 1", num, pvalid, vready); end
    endtask

    task automatic test_triangle();
        send_beat(10, 10, 1'b0, 1'b0);
        send_beat(50, 10, 1'b0, 1'b0);
        send_beat(30, 40, 1'b1, 1'b0);
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL tri_err got %b want 0", err); end
        pulse_frame();
        n_cmp++; if (xs !== pack4(10, 50, 30, 30)) begin n_bad++; $display("FAIL tri_xs got %h want %h", xs, pack4(10, 50, 30, 30)); end
        n_cmp++; if (ys !== pack4(10, 10, 40, 40)) begin n_bad++; $display("FAIL tri_ys got %h want %h", ys, pack4(10, 10, 40, 40)); end
        n_cmp++; if (num !== 3'd3) begin n_bad++; $display("FAIL tri_num got %0d want 3", num); end
    endtask

    task automatic test_overflow();
        int pulses = 0;
        for (int k = 1; k <= 6; k++) begin
            n_cmp++; if (vready !== 1'b1) begin n_bad++; $display("FAIL ovf_ready beat %0d got %b want 1", k, vready); end
            send_beat(10 + k, 20 + k, (k == 6), 1'b0);
            if (err === 1'b1) pulses++;
        end
        @(posedge clk);
        #1;
        if (err === 1'b1) pulses++;
        n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL ovf_err_pulses got %0d want 1", pulses); end
        pulse_frame();
        n_cmp++; if (xs !== pack4(11, 12, 13, 14)) begin n_bad++; $display("FAIL ovf_xs got %h want %h", xs, pack4(11, 12, 13, 14)); end
        n_cmp++; if (ys !== pack4(21, 22, 23, 24)) begin n_bad++; $display("FAIL ovf_ys got %h want %h", ys, pack4(21, 22, 23, 24)); end
        n_cmp++; if (num !== 3'd4) begin n_bad++; $display("FAIL ovf_num got %0d want 4", num); end
    endtask

    task automatic test_underflow();
        send_beat(7, 8, 1'b0, 1'b0);
        send_beat(9, 10, 1'b1, 1'b0);
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL udf_err got %b want 1", err); end
        n_cmp++; if (vready !== 1'b1) begin n_bad++; $display("FAIL udf_ready got %b want 1", vready); end
        pulse_frame();
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL udf_err_clear got %b want 0", err); end
        n_cmp++; if (xs !== pack4(11, 12, 13, 14) || num !== 3'd4) begin n_bad++; $display("FAIL udf_active_held got xs=%h num=%0d want %h 4", xs, num, pack4(11, 12, 13, 14)); end
        send_beat(1, 2, 1'b0, 1'b0);
        send_beat(3, 4, 1'b0, 1'b0);
        send_beat(5, 6, 1'b1, 1'b0);
        pulse_frame();
        n_cmp++; if (xs !== pack4(1, 3, 5, 5) || ys !== pack4(2, 4, 6, 6)) begin n_bad++; $display("FAIL udf_next_poly got xs=%h ys=%h want %h %h", xs, ys, pack4(1, 3, 5, 5), pack4(2, 4, 6, 6)); end
    endtask

    task automatic test_back_to_back();
        send_beat(100, 1, 1'b0, 1'b0);
        send_beat(101, 2, 1'b0, 1'b1);
        send_beat(102, 3, 1'b1, 1'b1);
        n_cmp++; if (xs !== pack4(1, 3, 5, 5) || num !== 3'd3) begin n_bad++; $display("FAIL b2b_no_commit got xs=%h num=%0d want %h 3", xs, num, pack4(1, 3, 5, 5)); end
        n_cmp++; if (vready !== 1'b0) begin n_bad++; $display("FAIL b2b_pending got ready=%b want 0", vready); end
        pulse_frame();
        n_cmp++; if (xs !== pack4(100, 101, 102, 102) || ys !== pack4(1, 2, 3, 3)) begin n_bad++; $display("FAIL b2b_commit got xs=%h ys=%h want %h %h", xs, ys, pack4(100, 101, 102, 102), pack4(1, 2, 3, 3)); end
    endtask

    task automatic test_reset_mid_stream();
        send_beat(40, 41, 1'b0, 1'b0);
        send_beat(42, 43, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (xs !== 128'd0 || ys !== 128'd0) begin n_bad++; $display("FAIL midrst_arrays got xs=%h ys=%h want 0 0", xs, ys); end
        n_cmp++; if ({num, pvalid, err} !== 5'd0) begin n_bad++; $display("FAIL midrst_ctl got %b want 00000", {num, pvalid, err}); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (vready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready got %b want 1", vready); end
        pulse_frame();
        n_cmp++; if (pvalid !== 1'b0) begin n_bad++; $display("FAIL midrst_no_commit got valid=%b want 0", pvalid); end
        send_beat(7, 70, 1'b0, 1'b0);
        send_beat(8, 80, 1'b0, 1'b0);
        send_beat(9, 90, 1'b1, 1'b0);
        pulse_frame();
        n_cmp++; if (xs !== pack4(7, 8, 9, 9) || num !== 3'd3 || pvalid !== 1'b1) begin n_bad++; $display("FAIL midrst_fresh got xs=%h num=%0d valid=%b want %h 3 1", xs, num, pvalid, pack4(7, 8, 9, 9)); end
    endtask

    initial begin
        test_reset();
        test_square();
        test_triangle();
        test_overflow();
        test_underflow();
        test_back_to_back();
        test_reset_mid_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
